layer_data_writer: RTL and testbench



---
 rtl/layer_data_writer_pkg.sv | 19 +
 rtl/layer_data_writer_if.sv | 32 +++
 rtl/layer_data_writer.sv | 130 +++++++++++++
 tb/tb_layer_data_writer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/layer_data_writer_pkg.sv
// Shared constants and types for the layer data writer: command bytes,
// FSM state encoding and default WS281x bit-timing counts.
package layer_pkg;

    localparam logic [7:0] CMD_CONF = 8'h2A;
    localparam logic [7:0] CMD_DATA = 8'h2C;

    localparam logic [7:0] T0H_DEF_C = 8'd15;
    localparam logic [7:0] T0L_DEF_C = 8'd40;
    localparam logic [7:0] T1H_DEF_C = 8'd40;
    localparam logic [7:0] T1L_DEF_C = 8'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONF = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/layer_data_writer_if.sv
// Host byte stream in, layer-RAM write port and timing counts out.
// slave = the writer block, master = whoever feeds bytes and observes.
interface layer_data_writer_if;

    logic       byte_rdy_in;
    logic [7:0] byte_data_in;
    logic       dc_in;

    logic       wr_en_out;
    logic       wr_done_out;
    logic [5:0] wr_addr_out;
    logic [7:0] wr_data_out;
    logic [3:0] wr_byte_en_out;

    logic [7:0] t0h_cnt_out;
    logic [7:0] t0l_cnt_out;
    logic [7:0] t1h_cnt_out;
    logic [7:0] t1l_cnt_out;

    modport slave (
        input  byte_rdy_in, byte_data_in, dc_in,
        output wr_en_out, wr_done_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        output t0h_cnt_out, t0l_cnt_out, t1h_cnt_out, t1l_cnt_out
    );

    modport master (
        output byte_rdy_in, byte_data_in, dc_in,
        input  wr_en_out, wr_done_out, wr_addr_out, wr_data_out, wr_byte_en_out,
        input  t0h_cnt_out, t0l_cnt_out, t1h_cnt_out, t1l_cnt_out
    );

endinterface

// File: rtl/layer_data_writer.sv
// Layer data writer: parses command/data bytes into layer-RAM byte writes
// and WS281x bit-timing settings. Single flat FSM with counters.
// Optional: LAYER_DATA_WRITER_TIMING_CHECK_EN rejects timing sets that
// contain a zero count (outputs keep their previous values).
module layer_data_writer
    import layer_pkg::*;
#(
    parameter int         FRAME_BYTES = 256,
    parameter logic [7:0] T0H_DEF     = T0H_DEF_C,
    parameter logic [7:0] T0L_DEF     = T0L_DEF_C,
    parameter logic [7:0] T1H_DEF     = T1H_DEF_C,
    parameter logic [7:0] T1L_DEF     = T1L_DEF_C
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    layer_data_writer_if.slave   bus
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    state_t     state_q;
    logic [7:0] idx_q;
    logic [1:0] cfg_cnt_q;
    logic [7:0] sh_t0h_q, sh_t0l_q, sh_t1h_q;
    logic       done_pend_q;

    logic       wr_en_q, wr_done_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [3:0] wr_be_q;
    logic [7:0] t0h_q, t0l_q, t1h_q, t1l_q;

    // Completed timing set is acceptable for commit (4th byte arrives live).
    logic       cfg_ok;
`ifdef LAYER_DATA_WRITER_TIMING_CHECK_EN
    assign cfg_ok = (sh_t0h_q != 8'd0) && (sh_t0l_q != 8'd0) &&
                    (sh_t1h_q != 8'd0) && (bus.byte_data_in != 8'd0);
`else
    assign cfg_ok = 1'b1;
`endif

    // Command decode, config capture and frame write sequencing.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            cfg_cnt_q   <= 2'd0;
            sh_t0h_q    <= 8'd0;
            sh_t0l_q    <= 8'd0;
            sh_t1h_q    <= 8'd0;
            done_pend_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            wr_be_q     <= 4'd0;
            t0h_q       <= T0H_DEF;
            t0l_q       <= T0L_DEF;
            t1h_q       <= T1H_DEF;
            t1l_q       <= T1L_DEF;
        end else begin
            // Strobes default low; done trails the final write by one cycle.
            wr_en_q     <= 1'b0;
            wr_done_q   <= done_pend_q;
            done_pend_q <= 1'b0;

            if (bus.byte_rdy_in) begin
                if (!bus.dc_in) begin
                    // Commands abort whatever is in progress.
                    case (bus.byte_data_in)
                        CMD_CONF: begin
                            state_q   <= CONF;
                            cfg_cnt_q <= 2'd0;
                        end
                        CMD_DATA: begin
                            state_q <= DATA;
                            idx_q   <= 8'd0;
                        end
                        default: state_q <= IDLE;
                    endcase
                end else begin
                    case (state_q)
                        CONF: begin
                            cfg_cnt_q <= cfg_cnt_q + 2'd1;
                            case (cfg_cnt_q)
                                2'd0: sh_t0h_q <= bus.byte_data_in;
                                2'd1: sh_t0l_q <= bus.byte_data_in;
                                2'd2: sh_t1h_q <= bus.byte_data_in;
                                default: begin
                                    // Publish all four counts in one edge.
                                    if (cfg_ok) begin
                                        t0h_q <= sh_t0h_q;
                                        t0l_q <= sh_t0l_q;
                                        t1h_q <= sh_t1h_q;
                                        t1l_q <= bus.byte_data_in;
                                    end
                                    state_q <= IDLE;
                                end
                            endcase
                        end
                        DATA: begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= idx_q[7:2];
                            wr_be_q   <= 4'b1000 >> idx_q[1:0];
                            wr_data_q <= bus.byte_data_in;
                            if (idx_q == LAST_IDX) begin
                                done_pend_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                idx_q <= idx_q + 8'd1;
                            end
                        end
                        default: ;  // IDLE ignores data bytes
                    endcase
                end
            end
        end
    end

    assign bus.wr_en_out      = wr_en_q;
    assign bus.wr_done_out    = wr_done_q;
    assign bus.wr_addr_out    = wr_addr_q;
    assign bus.wr_data_out    = wr_data_q;
    assign bus.wr_byte_en_out = wr_be_q;
    assign bus.t0h_cnt_out    = t0h_q;
    assign bus.t0l_cnt_out    = t0l_q;
    assign bus.t1h_cnt_out    = t1h_q;
    assign bus.t1l_cnt_out    = t1l_q;

endmodule

// File: tb/tb_layer_data_writer.sv
// Directed bench for layer_data_writer: reset state, timing config,
// full and aborted frames, reset mid-config, optional zero-count rejection.
module tb_layer_data_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   done_base;

    layer_data_writer_if bus ();

    layer_data_writer dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Count wr_done pulses, sampled away from the active edge.
    always @(negedge clk) if (bus.wr_done_out === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic dc, input logic [7:0] b);
        @(negedge clk);
        bus.byte_rdy_in  = rdy;
        bus.dc_in        = dc;
        bus.byte_data_in = b;
    endtask

    task automatic chk_timing(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        chk({tag, "_t0h"}, 32'(bus.t0h_cnt_out), 32'(a));
        chk({tag, "_t0l"}, 32'(bus.t0l_cnt_out), 32'(b));
        chk({tag, "_t1h"}, 32'(bus.t1h_cnt_out), 32'(c));
        chk({tag, "_t1l"}, 32'(bus.t1l_cnt_out), 32'(d));
    endtask

    // Expected write produced by frame byte j (data value equals j here).
    task automatic chk_wr(input int j);
        logic [3:0] lane;
        lane = 4'b1000 >> (j % 4);
        chk($sformatf("wr_en_%0d", j),   32'(bus.wr_en_out), 32'd1);
        chk($sformatf("wr_addr_%0d", j), 32'(bus.wr_addr_out), 32'(j / 4));
        chk($sformatf("wr_be_%0d", j),   32'(bus.wr_byte_en_out), 32'(lane));
        chk($sformatf("wr_data_%0d", j), 32'(bus.wr_data_out), 32'(j & 8'hFF));
        chk($sformatf("wr_done_%0d", j), 32'(bus.wr_done_out), 32'd0);
    endtask

    // n back-to-back data bytes 0,1,2..; each checks the previous write.
    task automatic data_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            if (i == 0) chk("wr_en_first", 32'(bus.wr_en_out), 32'd0);
            else        chk_wr(i - 1);
        end
    endtask

    // Close a full 256-byte frame: last write, then a single done pulse.
    task automatic frame_tail();
        drive(1'b0, 1'b0, 8'h00);
        chk_wr(255);
        drive(1'b0, 1'b0, 8'h00);
        chk("done_pulse", 32'(bus.wr_done_out), 32'd1);
        chk("done_en_low", 32'(bus.wr_en_out), 32'd0);
        chk("done_addr_hold", 32'(bus.wr_addr_out), 32'd63);
        chk("done_be_hold", 32'(bus.wr_byte_en_out), 32'b0001);
        drive(1'b0, 1'b0, 8'h00);
        chk("done_one_cycle", 32'(bus.wr_done_out), 32'd0);
    endtask

    initial begin
        bus.byte_rdy_in  = 1'b0;
        bus.dc_in        = 1'b0;
        bus.byte_data_in = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_wr_en",   32'(bus.wr_en_out), 32'd0);
        chk("rst_wr_done", 32'(bus.wr_done_out), 32'd0);
        chk("rst_addr",    32'(bus.wr_addr_out), 32'd0);
        chk("rst_data",    32'(bus.wr_data_out), 32'd0);
        chk("rst_be",      32'(bus.wr_byte_en_out), 32'd0);
        chk_timing("rst", 8'd15, 8'd40, 8'd40, 8'd15);

        // Timing config: no partial update, all four land together
        drive(1'b1, 1'b0, 8'h2A);
        drive(1'b1, 1'b1, 8'h0A);
        drive(1'b1, 1'b1, 8'h1E);
        drive(1'b1, 1'b1, 8'h1E);
        drive(1'b1, 1'b1, 8'h0A);
        chk_timing("cfg_partial", 8'd15, 8'd40, 8'd40, 8'd15);
        drive(1'b0, 1'b0, 8'h00);
        chk_timing("cfg_commit", 8'd10, 8'd30, 8'd30, 8'd10);
        chk("cfg_no_wr", 32'(bus.wr_en_out), 32'd0);

        // Data byte after config completes lands in IDLE and is ignored
        drive(1'b1, 1'b1, 8'h77);
        drive(1'b0, 1'b0, 8'h00);
        chk("cfg_idle_no_wr", 32'(bus.wr_en_out), 32'd0);
        chk_timing("cfg_idle_hold", 8'd10, 8'd30, 8'd30, 8'd10);

        // Full frame, back-to-back bytes 0x00..0xFF
        done_base = done_cnt;
        drive(1'b1, 1'b0, 8'h2C);
        data_bytes(256);
        frame_tail();
        chk("frame1_done_count", 32'(done_cnt - done_base), 32'd1);

        // Aborted frame of 10 bytes, then a full frame restarting at 0
        done_base = done_cnt;
        drive(1'b1, 1'b0, 8'h2C);
        data_bytes(10);
        drive(1'b1, 1'b0, 8'h2C);
        chk_wr(9);
        data_bytes(256);
        frame_tail();
        chk("frame2_done_count", 32'(done_cnt - done_base), 32'd1);

        // Reset mid-config restores defaults; later data byte ignored
        drive(1'b1, 1'b0, 8'h2A);
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 8'h02);
        @(negedge clk);
        bus.byte_rdy_in = 1'b0;
        rst = 1'b1;
        #1;
        chk_timing("midrst", 8'd15, 8'd40, 8'd40, 8'd15);
        chk("midrst_addr", 32'(bus.wr_addr_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b0, 1'b0, 8'h00);
        chk("midrst_idle_no_wr", 32'(bus.wr_en_out), 32'd0);
        chk("midrst_idle_data", 32'(bus.wr_data_out), 32'd0);
        chk_timing("midrst_idle", 8'd15, 8'd40, 8'd40, 8'd15);

        // Config set containing a zero count
        drive(1'b1, 1'b0, 8'h2A);
        drive(1'b1, 1'b1, 8'h0A);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h1E);
        drive(1'b1, 1'b1, 8'h0A);
        drive(1'b0, 1'b0, 8'h00);
`ifdef LAYER_DATA_WRITER_TIMING_CHECK_EN
        chk_timing("zero_cfg", 8'd15, 8'd40, 8'd40, 8'd15);
`else
        chk_timing("zero_cfg", 8'd10, 8'd0, 8'd30, 8'd10);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
